regfile_sb_bypass: RTL
======================

// Module: regfile_sb_bypass
// PURPOSE
//  Parametrised successor to the Solix-16 DFF register file: NUM_GPR general registers plus SP, PC and FLAGS.
//  Adds same-cycle write-to-read bypass, a per-GPR busy scoreboard, SP push/pop arithmetic with stack bounds,
//  PC auto-increment and masked FLAGS update. Sits between decode (reads, scoreboard) and writeback (rd write).
// PARAMETERS
//  DATA_W     16       register width
//  NUM_GPR    8        general registers, index 0..NUM_GPR-1; SP=NUM_GPR, PC=NUM_GPR+1, FLAGS=NUM_GPR+2
//  ADDR_W     4        register index width; NUM_GPR+3 <= 2**ADDR_W
//  PC_STEP    2        PC increment amount
//  SP_RESET   16'hFFFE SP value after reset; also the stack top bound
//  SP_LIMIT   16'hF000 lowest legal SP; pushes below it are refused
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst_n       in   1       synchronous reset, active-low
//  rs_addr     in   ADDR_W  read port A index
//  rt_addr     in   ADDR_W  read port B index
//  rs_data     out  DATA_W  read port A data (combinational)
//  rt_data     out  DATA_W  read port B data (combinational)
//  rs_busy     out  1       port A index is a GPR with a pending write
//  rt_busy     out  1       port B index is a GPR with a pending write
//  wr_en       in   1       GPR writeback strobe
//  rd_addr     in   ADDR_W  writeback index
//  rd_data     in   DATA_W  writeback data
//  sb_set      in   1       mark sb_addr busy (instruction issued)
//  sb_addr     in   ADDR_W  scoreboard set index
//  sb_err      out  1       registered pulse: sb_set on an already-busy GPR
//  sp_op       in   2       00 hold, 01 push (SP-=2), 10 pop (SP+=2), 11 load sp_in
//  sp_in       in   DATA_W  SP load value
//  stack_fault out  1       registered pulse: push/pop refused at a bound
//  pc_op       in   2       00 hold, 01 PC+=PC_STEP, 10 load pc_in, 11 hold
//  pc_in       in   DATA_W  PC load value
//  flags_wr    in   1       FLAGS update strobe
//  flags_mask  in   DATA_W  bit-wise write mask for FLAGS
//  flags_in    in   DATA_W  FLAGS new value
//  sp_out, pc_out, flags_out  out DATA_W  current registered SP/PC/FLAGS (no bypass)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): GPRs=0, busy=0, PC=0, FLAGS=0, SP=SP_RESET, sb_err=0, stack_fault=0; all other inputs ignored.
//  Reads: index<NUM_GPR -> GPR; NUM_GPR/+1/+2 -> SP/PC/FLAGS; higher index -> 0, busy=0.
//  Bypass: wr_en && rd_addr==rs_addr && rd_addr<NUM_GPR -> rs_data=rd_data same cycle (same for rt). Zero-latency.
//  Bypass also for specials: read of SP/PC/FLAGS returns the value they will hold after this edge.
//  Writes: GPR written at edge when wr_en && rd_addr<NUM_GPR; wr_en with rd_addr>=NUM_GPR is ignored (no special write).
//  Scoreboard: busy[i] set by sb_set&&sb_addr==i; cleared by wr_en&&rd_addr==i.
//   Set and clear same GPR same cycle -> busy stays 1 (new issue wins). sb_set on index>=NUM_GPR ignored.
//   rs_busy/rt_busy reflect busy bits after bypass: a GPR being cleared this cycle reads busy=0 unless also set.
//   sb_err=1 for one cycle after an edge where sb_set hit a GPR busy and not cleared that cycle; state unchanged otherwise.
//  SP: push when SP-2 < SP_LIMIT (incl. wrap below 0) -> SP unchanged, stack_fault pulse.
//   Pop when SP+2 > SP_RESET (incl. wrap) -> SP unchanged, stack_fault pulse. Load (11) unchecked.
//  PC: increment wraps modulo 2**DATA_W.
//  FLAGS: new = (FLAGS & ~flags_mask) | (flags_in & flags_mask) when flags_wr.
//  Reset mid-operation wins over every strobe in that cycle; pending busy bits are discarded.
// TESTING
//  Reset with all strobes high -> after edge GPRs=0, SP=FFFE, PC=0, FLAGS=0, sb_err=0, stack_fault=0.
//  wr_en rd_addr=3 rd_data=A5A5, rs_addr=3, rt_addr=3 same cycle -> rs_data=rt_data=A5A5 before edge; R3=A5A5 after.
//  sb_set R2; next cycle rs_addr=2 -> rs_busy=1; sb_set R2 again -> sb_err pulse; wr_en R2 -> busy=0 next cycle.
//  Same cycle sb_set R5 and wr_en R5 -> R5 written, busy[5]=1 after edge, no sb_err.
//  SP=F000, push -> SP stays F000, stack_fault=1 for one cycle; SP=FFFE, pop -> fault, SP=FFFE; push from FFFE -> FFFC.
//  PC=FFFE, pc_op=01 -> PC=0000; FLAGS=00F0, flags_wr mask=000F in=FFFF -> FLAGS=00FF.

Source files
------------

// File: rtl/regfile_sb_bypass.sv
// regfile_sb_bypass: register file with NUM_GPR general registers plus SP, PC and FLAGS.
// Reads are combinational and see this cycle's writeback and special-register updates.
// A busy scoreboard tracks GPRs with an instruction in flight.
// SP push/pop is bounds-checked against SP_LIMIT and SP_RESET.
module regfile_sb_bypass #(
    parameter int DATA_W  = 16,
    parameter int NUM_GPR = 8,
    parameter int ADDR_W  = 4,
    parameter int PC_STEP = 2,
    parameter logic [DATA_W-1:0] SP_RESET = 16'hFFFE,
    parameter logic [DATA_W-1:0] SP_LIMIT = 16'hF000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic              sb_err,
    input  logic [1:0]        sp_op,
    input  logic [DATA_W-1:0] sp_in,
    output logic              stack_fault,
    input  logic [1:0]        pc_op,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              flags_wr,
    input  logic [DATA_W-1:0] flags_mask,
    input  logic [DATA_W-1:0] flags_in,
    output logic [DATA_W-1:0] sp_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] flags_out
);

    localparam logic [ADDR_W-1:0] SP_IDX  = ADDR_W'(NUM_GPR);
    localparam logic [ADDR_W-1:0] PC_IDX  = ADDR_W'(NUM_GPR + 1);
    localparam logic [ADDR_W-1:0] FL_IDX  = ADDR_W'(NUM_GPR + 2);
    localparam logic [DATA_W-1:0] PC_INC  = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] SP_STEP = DATA_W'(2);

    logic [DATA_W-1:0]  gpr [NUM_GPR];
    logic [NUM_GPR-1:0] busy;
    logic [NUM_GPR-1:0] busy_set;
    logic [NUM_GPR-1:0] wr_hit;
    logic [NUM_GPR-1:0] busy_next;
    logic [DATA_W-1:0]  sp;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  flags;
    logic [DATA_W-1:0]  sp_next;
    logic [DATA_W-1:0]  pc_next;
    logic [DATA_W-1:0]  flags_next;
    logic [DATA_W:0]    sp_dec;
    logic [DATA_W:0]    sp_inc;
    logic               sb_err_q;
    logic               sb_err_next;
    logic               fault_q;
    logic               fault_next;
    logic               wr_gpr;

    assign wr_gpr      = wr_en && (rd_addr < SP_IDX);
    assign sp_out      = sp;
    assign pc_out      = pc;
    assign flags_out   = flags;
    assign sb_err      = sb_err_q;
    assign stack_fault = fault_q;

    // Decode writeback and issue per GPR; a set in the same cycle as a clear keeps the register busy
    always_comb begin
        busy_set    = '0;
        wr_hit      = '0;
        sb_err_next = 1'b0;
        for (int i = 0; i < NUM_GPR; i++) begin
            busy_set[i] = sb_set && (sb_addr == ADDR_W'(i));
            wr_hit[i]   = wr_en && (rd_addr == ADDR_W'(i));
            if (busy_set[i] && busy[i] && !wr_hit[i]) begin
                sb_err_next = 1'b1;
            end
        end
        busy_next = (busy & ~wr_hit) | busy_set;
    end

    // SP arithmetic with one extra bit so wrap past 0 or past the top is caught as out of bounds
    always_comb begin
        sp_dec     = {1'b0, sp} - {1'b0, SP_STEP};
        sp_inc     = {1'b0, sp} + {1'b0, SP_STEP};
        sp_next    = sp;
        fault_next = 1'b0;
        case (sp_op)
            2'b01: begin
                if (sp_dec[DATA_W] || (sp_dec[DATA_W-1:0] < SP_LIMIT)) begin
                    fault_next = 1'b1;
                end else begin
                    sp_next = sp_dec[DATA_W-1:0];
                end
            end
            2'b10: begin
                if (sp_inc > {1'b0, SP_RESET}) begin
                    fault_next = 1'b1;
                end else begin
                    sp_next = sp_inc[DATA_W-1:0];
                end
            end
            2'b11:   sp_next = sp_in;
            default: sp_next = sp;
        endcase
    end

    // PC step/load and bit-masked FLAGS merge
    always_comb begin
        pc_next = pc;
        case (pc_op)
            2'b01:   pc_next = pc + PC_INC;
            2'b10:   pc_next = pc_in;
            default: pc_next = pc;
        endcase
        flags_next = flags;
        if (flags_wr) begin
            flags_next = (flags & ~flags_mask) | (flags_in & flags_mask);
        end
    end

    // Read ports: stored GPR, then writeback bypass, then the post-edge value of the specials
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (rs_addr == ADDR_W'(i)) begin
                rs_data = gpr[i];
                rs_busy = busy_next[i];
            end
            if (rt_addr == ADDR_W'(i)) begin
                rt_data = gpr[i];
                rt_busy = busy_next[i];
            end
        end
        if (wr_gpr && (rd_addr == rs_addr)) begin
            rs_data = rd_data;
        end
        if (wr_gpr && (rd_addr == rt_addr)) begin
            rt_data = rd_data;
        end
        case (rs_addr)
            SP_IDX:  rs_data = sp_next;
            PC_IDX:  rs_data = pc_next;
            FL_IDX:  rs_data = flags_next;
            default: rs_data = rs_data;
        endcase
        case (rt_addr)
            SP_IDX:  rt_data = sp_next;
            PC_IDX:  rt_data = pc_next;
            FL_IDX:  rt_data = flags_next;
            default: rt_data = rt_data;
        endcase
    end

    // State update; reset overrides every strobe and drops pending busy bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
            busy     <= '0;
            sp       <= SP_RESET;
            pc       <= '0;
            flags    <= '0;
            sb_err_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (wr_hit[i]) begin
                    gpr[i] <= rd_data;
                end
            end
            busy     <= busy_next;
            sp       <= sp_next;
            pc       <= pc_next;
            flags    <= flags_next;
            sb_err_q <= sb_err_next;
            fault_q  <= fault_next;
        end
    end

endmodule
